// File: rtl/ip_send.sv
// ip_send: IPv4 transmit framer; buffers UDP bytes in a FIFO and prepends a 20-byte header with checksum.
// Define IP_ID_INC_EN to make the identification field count packets; otherwise it stays 0000.
module ip_send #(
   parameter int          FIFO_DEPTH = 64,
   parameter logic [31:0] SRC_IP     = 32'hC0A8010A,
   parameter logic [7:0]  TTL        = 8'h40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        udp_axis_tvalid_in,
   input  logic [7:0]  udp_axis_tdata_in,
   input  logic        udp_axis_tlast_in,
   input  logic [31:0] ip_addr_in,
   input  logic [15:0] length_in,
   input  logic        ip_axis_tready_in,
   output logic        ip_axis_tvalid_out,
   output logic [7:0]  ip_axis_tdata_out,
   output logic        ip_axis_tlast_out,
   output logic [31:0] ip_dest_out,
   output logic        busy_out,
   output logic        overflow_out
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, CSUM0, CSUM1, CSUM2, HDR, PAYLOAD} state_t;
   state_t state, state_nx;

   logic [8:0]  mem [FIFO_DEPTH];
   logic [8:0]  head;
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic        empty, full, push, pop, sop, meta_valid, meta_block, hdr_done, pkt_done, overflow;
   logic [31:0] meta_ip, dst;
   logic [15:0] meta_len, tl, total_len, csum, id;
   logic [19:0] sum, sum0, fold;
   logic [4:0]  cnt;
   logic [7:0]  hdr [20];

   assign count      = wr_ptr - rd_ptr;
   assign empty      = count == '0;
   assign full       = count[AW];
   assign head       = mem[rd_ptr[AW-1:0]];
   assign pop        = state == PAYLOAD && !empty && ip_axis_tready_in;
   // a pop in the same cycle frees the slot, so a write on full is not a drop
   assign push       = udp_axis_tvalid_in && (!full || pop);
   assign meta_block = meta_valid && state != PAYLOAD;
   assign hdr_done   = state == HDR && ip_axis_tready_in && cnt == 5'd19;
   assign pkt_done   = pop && head[8];

   assign tl   = meta_len + 16'd20;
   assign sum0 = 20'h04500 + {4'h0, tl} + {4'h0, id} + 20'h04000 + {4'h0, TTL, 8'h11}
               + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]} + {4'h0, meta_ip[31:16]} + {4'h0, meta_ip[15:0]};
   assign fold = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
   assign hdr  = '{8'h45, 8'h00, total_len[15:8], total_len[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
                   TTL, 8'h11, csum[15:8], csum[7:0], SRC_IP[31:24], SRC_IP[23:16], SRC_IP[15:8],
                   SRC_IP[7:0], dst[31:24], dst[23:16], dst[15:8], dst[7:0]};

   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= {udp_axis_tlast_in, udp_axis_tdata_in};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sop        <= 1'b1;
         meta_valid <= 1'b0;
         meta_ip    <= '0;
         meta_len   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push) sop <= udp_axis_tlast_in;
         if ((udp_axis_tvalid_in && !push) || (push && sop && meta_block)) overflow <= 1'b1;
         if (push && sop && !meta_block) begin
            meta_ip    <= ip_addr_in;
            meta_len   <= length_in;
            meta_valid <= 1'b1;
         end else if (hdr_done) meta_valid <= 1'b0;
      end
   end

`ifdef IP_ID_INC_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) id <= '0;
      else if (pkt_done) id <= id + 1'b1;
`else
   assign id = 16'h0000;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum       <= '0;
         csum      <= '0;
         total_len <= '0;
         dst       <= '0;
         cnt       <= '0;
      end else begin
         if (state == CSUM0) begin
            sum       <= sum0;
            total_len <= tl;
            dst       <= meta_ip;
         end
         if (state == CSUM1) sum <= fold;
         if (state == CSUM2) csum <= ~fold[15:0];
         if (state == HDR && ip_axis_tready_in) cnt <= hdr_done ? 5'd0 : cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (meta_valid) state_nx = CSUM0;
         CSUM0:   state_nx = CSUM1;
         CSUM1:   state_nx = CSUM2;
         CSUM2:   state_nx = HDR;
         HDR:     if (hdr_done) state_nx = PAYLOAD;
         PAYLOAD: if (pkt_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      ip_axis_tvalid_out = state == HDR || (state == PAYLOAD && !empty);
      ip_axis_tdata_out  = state == HDR ? hdr[cnt] : (state == PAYLOAD && !empty) ? head[7:0] : 8'h00;
      ip_axis_tlast_out  = state == PAYLOAD && !empty && head[8];
   end

   assign ip_dest_out  = dst;
   assign busy_out     = state != IDLE;
   assign overflow_out = overflow;
endmodule

// File: tb/tb_ip_send.sv
// tb_ip_send: randomized and directed checks of ip_send against a header/payload reference model.
module tb_ip_send;
   localparam logic [31:0] SRC_IP = 32'hC0A8010A;
   localparam logic [7:0]  TTL    = 8'h40;
`ifdef IP_ID_INC_EN
   localparam logic [15:0] ID2 = 16'h0001, CS2 = 16'hB76F;
`else
   localparam logic [15:0] ID2 = 16'h0000, CS2 = 16'hB770;
`endif

   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0, tready = 1'b1;
   logic [7:0]  in_data = '0;
   logic [31:0] in_ip = '0;
   logic [15:0] in_len = '0;
   logic        out_valid, out_last, busy, overflow;
   logic [7:0]  out_data;
   logic [31:0] out_dest;

   int checks = 0, errors = 0;
   logic [7:0]  ex_d [8192];
   logic        ex_l [8192];
   logic [31:0] ex_a [8192];
   logic [7:0]  got_d [8192];
   int          wi = 0, ri = 0, rdy_mode = 0;
   bit          mon_en = 1'b0;
   logic [15:0] m_id = '0;
   logic [7:0]  pl [64];

   ip_send dut (
      .clk(clk), .reset(reset),
      .udp_axis_tvalid_in(in_valid), .udp_axis_tdata_in(in_data), .udp_axis_tlast_in(in_last),
      .ip_addr_in(in_ip), .length_in(in_len), .ip_axis_tready_in(tready),
      .ip_axis_tvalid_out(out_valid), .ip_axis_tdata_out(out_data), .ip_axis_tlast_out(out_last),
      .ip_dest_out(out_dest), .busy_out(busy), .overflow_out(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RFC 791 header: one's-complement sum of 16-bit words with the checksum slot zero
   function automatic logic [159:0] model_hdr(logic [31:0] d, logic [15:0] len, logic [15:0] id);
      logic [15:0] w [10];
      int unsigned s;
      w = '{16'h4500, 16'(len + 16'd20), id, 16'h4000, {TTL, 8'h11}, 16'h0000,
            SRC_IP[31:16], SRC_IP[15:0], d[31:16], d[15:0]};
      s = 0;
      for (int i = 0; i < 10; i++) s = s + 32'(w[i]);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      w[5] = ~s[15:0];
      return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], w[9]};
   endfunction

   task automatic push_pkt(int n, logic [31:0] d, logic [15:0] len);
      logic [159:0] hv;
      hv = model_hdr(d, len, m_id);
      for (int i = 0; i < 20; i++) begin
         ex_d[wi] = hv[159:152]; ex_l[wi] = 1'b0; ex_a[wi] = d; wi++;
         hv = hv << 8;
      end
      for (int i = 0; i < n; i++) begin
         ex_d[wi] = pl[i]; ex_l[wi] = (i == n - 1); ex_a[wi] = d; wi++;
      end
`ifdef IP_ID_INC_EN
      m_id = m_id + 16'd1;
`endif
   endtask

   task automatic send_pkt(int n, logic [31:0] d, logic [15:0] len, bit gappy);
      for (int i = 0; i < n; i++) begin
         if (gappy && $urandom_range(3) == 0) begin
            in_valid = 1'b0; @(posedge clk); #1;
         end
         in_valid = 1'b1; in_data = pl[i]; in_last = (i == n - 1);
         in_ip  = i == 0 ? d : $urandom;
         in_len = i == 0 ? len : 16'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_left(int lim);
      int n = 0;
      while (wi - ri > lim && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      check("drain", (wi - ri > lim) ? wi - ri : lim, lim);
   endtask

   task automatic measure_latency();
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk); seen = out_valid;
      end
      check("latency", n - 1, 4);
   endtask

   task automatic do_reset();
      reset = 1'b1; mon_en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; m_id = '0; mon_en = 1'b1;
   endtask

   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0: tready = 1'b1;
         1: tready = ~tready;
         2: tready = $urandom_range(3) != 0;
         default: tready = 1'b0;
      endcase
   end

   // monitor: every output transfer is matched against the model stream in order
   initial begin
      bit hold_v;
      logic [8:0] hold_d;
      hold_v = 1'b0; hold_d = '0;
      forever begin
         @(negedge clk);
         if (!mon_en || reset) begin
            ri = wi; hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", {out_last, out_data}, hold_d);
            end
            if (out_valid && tready) begin
               if (ri == wi) check("extra_byte", ri, wi + 1);
               else begin
                  check("byte", out_data, ex_d[ri]);
                  check("tlast", out_last, ex_l[ri]);
                  check("dest", out_dest, ex_a[ri]);
                  got_d[ri] = out_data;
                  ri++;
               end
            end
            hold_v = out_valid && !tready;
            hold_d = {out_last, out_data};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base, base2, n, n_prev;
      logic [31:0] d;
      logic [15:0] len;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_dest", out_dest, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0; mon_en = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) pl[i] = 8'(i);
      base = wi;
      push_pkt(12, 32'hC0A80102, 16'd12);
      fork
         send_pkt(12, 32'hC0A80102, 16'd12, 1'b0);
         measure_latency();
      join
      wait_left(0);
      check("totlen", {got_d[base+2], got_d[base+3]}, 16'h0020);
      check("csum", {got_d[base+10], got_d[base+11]}, 16'hB770);
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);

      rdy_mode = 1;
      push_pkt(12, 32'hC0A80102, 16'd12);
      send_pkt(12, 32'hC0A80102, 16'd12, 1'b0);
      wait_left(0);
      rdy_mode = 0;

      do_reset();
      push_pkt(12, 32'hC0A80102, 16'd12);
      send_pkt(12, 32'hC0A80102, 16'd12, 1'b0);
      repeat (18) @(posedge clk);
      #1;
      base2 = wi;
      push_pkt(12, 32'hC0A80102, 16'd12);
      send_pkt(12, 32'hC0A80102, 16'd12, 1'b0);
      wait_left(0);
      check("id2", {got_d[base2+4], got_d[base2+5]}, ID2);
      check("csum2", {got_d[base2+10], got_d[base2+11]}, CS2);

      rdy_mode = 2; n_prev = 0;
      for (int p = 0; p < 20; p++) begin
         n = $urandom_range(30, 1);
         for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
         d = $urandom;
         len = p == 5 ? 16'hFFF0 : 16'($urandom);
         if (p > 0) wait_left(n_prev);
         repeat ($urandom_range(3)) @(posedge clk);
         #1;
         push_pkt(n, d, len);
         send_pkt(n, d, len, 1'b1);
         n_prev = n;
      end
      wait_left(0);
      rdy_mode = 0;
      check("rand_ovf", overflow, 0);

      do_reset();
      mon_en = 1'b0; rdy_mode = 3;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 70; i++) begin
         in_valid = 1'b1; in_data = 8'(i); in_last = (i == 69);
         in_ip = 32'hC0A80102; in_len = 16'd70;
         @(posedge clk); #1;
         if (i == 63) check("ovf_at_full", overflow, 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("ovf_set", overflow, 1);
      rdy_mode = 0;
      repeat (100) @(posedge clk);
      #1;
      check("ovf_sticky", overflow, 1);
      check("empty_busy", busy, 1);
      check("empty_novalid", out_valid, 0);

      do_reset();
      for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
      d = $urandom;
      push_pkt(8, d, 16'd8);
      send_pkt(8, d, 16'd8, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("pre_sop_ovf", overflow, 0);
      send_pkt(4, ~d, 16'd4, 1'b0);
      check("sop_ovf", overflow, 1);
      wait_left(0);
      repeat (3) @(posedge clk);
      #1;
      check("sop_idle", busy, 0);

      do_reset();
      for (int i = 0; i < 12; i++) pl[i] = 8'($urandom);
      d = $urandom;
      base = wi;
      push_pkt(12, d, 16'd12);
      send_pkt(12, d, 16'd12, 1'b0);
      n = 0;
      while (ri - base < 24 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("pre_rst_count", ri - base, 24);
      reset = 1'b1; mon_en = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_last", out_last, 0);
      @(posedge clk); #1;
      reset = 1'b0; m_id = '0; mon_en = 1'b1;
      for (int i = 0; i < 12; i++) pl[i] = 8'($urandom);
      d = $urandom;
      push_pkt(12, d, 16'd12);
      send_pkt(12, d, 16'd12, 1'b0);
      wait_left(0);
      check("post_rst_ovf", overflow, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
